moving_sum_iq: RTL
==================

Name: moving_sum_iq

Overview:
- Runtime-configurable complex (I/Q) moving-window summer/averager.
- Successor to the fixed-length, real-only moving summation block.
- Adds a complex datapath, a window length selectable at runtime up to MAX_LENGTH (power of two), an optional divide-by-length average, a window-primed flag and a synchronous clear.
- Sits in the receiver front end after the sample-rate stage; feeds energy/correlation detectors over a valid/ready stream.

Parameters:
- WIDTH, 16, signed bit width of each I and Q input sample.
- MAX_LENGTH, 64, maximum window length in samples; power of two, at least 2.
- GATE_UNPRIMED, 0, 1 = suppress output beats until the window has filled; 0 = emit every beat.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- cfg_log2_len  input  $clog2($clog2(MAX_LENGTH)+1)  window length L = 2**cfg_log2_len; legal range 1..$clog2(MAX_LENGTH)
- cfg_average  input  1  1 = output sum>>cfg_log2_len; 0 = raw sum
- clear  input  1  synchronous flush; also latches the cfg_* inputs
- s_valid  input  1  input beat valid
- s_ready  output  1  input beat ready
- s_data_i  input  WIDTH  signed in-phase sample
- s_data_q  input  WIDTH  signed quadrature sample
- m_valid  output  1  output beat valid
- m_ready  input  1  output beat ready
- m_data_i  output  WIDTH+$clog2(MAX_LENGTH)  signed I sum/average
- m_data_q  output  WIDTH+$clog2(MAX_LENGTH)  signed Q sum/average
- m_primed  output  1  window full; qualifies the current m_data

Behaviour:
- Reset (reset_n low, asynchronous):
  - m_valid=0, m_primed=0, m_data_i/q=0, sums=0.
  - Write pointer=0, fill count=0, state=FILL.
  - Config latched from the cfg_* pins on the first clock after release. Buffer contents are don't-care because FILL masks them.
- Config:
  - cfg_* are sampled only on reset release and on clear.
  - Changes at any other time are ignored.
  - An illegal cfg_log2_len (0 or >log2 MAX) is clamped to the nearest legal value.
- Handshake:
  - s_ready = !m_valid || m_ready, and s_ready=0 while clear is high.
  - A beat is accepted when s_valid && s_ready.
  - m_valid rises the cycle after acceptance (latency 1).
  - m_data stays stable while m_valid && !m_ready.
- Storage:
  - Circular buffer, MAX_LENGTH entries of 2*WIDTH bits, indexed by a write pointer that wraps at L-1 → 0.
  - On accept: read the entry at the pointer as the expired sample, write the new sample there, advance the pointer.
- Arithmetic:
  - sum_x <= sum_x + sext(new_x) - sext(expired_x), full width WIDTH+log2(MAX_LENGTH). No overflow is possible.
  - m_data is the updated sum, including the newly accepted sample.
  - Average mode applies an arithmetic right shift by log2 L, i.e. floor toward -inf, result sign-extended.
- State machine, FILL → RUN:
  - FILL: expired is forced to 0; the fill count increments per accept.
  - FILL→RUN on the accept that makes the count equal L. That output beat has m_primed=1.
  - RUN: expired is read from the buffer; m_primed stays 1.
- GATE_UNPRIMED=1: accepted beats in FILL update the sums but do not raise m_valid. The first emitted beat is the L-th sample.
- clear (synchronous, highest priority after reset):
  - Zeroes sums, pointer and fill count; state=FILL; m_valid=0, m_primed=0; latches cfg.
  - A beat presented in the same cycle is not accepted.
  - A pending unread output beat is discarded.
- Simultaneous accept and output drain in the same cycle is legal and sustains 1 beat/clock.
- I and Q use identical, independent arithmetic.

Test Plan:
- L=4, raw mode, I=3, Q=-2 constant, m_ready=1 → m_data_i 3,6,9,12,12,12; Q -2,-4,-6,-8,-8; m_primed first high on the 4th beat.
- L=4, average mode, I sequence 4,8,-4,0,12 → raw sums 4,12,8,8,16 → outputs 1,3,2,2,4; negative window case: sum -5 → -2 (floor).
- Backpressure: hold m_ready=0 for 5 cycles with s_valid=1 → one beat held stable, s_ready=0, no sample lost; a resumed random ready pattern matches the reference-model sum sequence exactly.
- MAX_LENGTH=64, L=64, all samples +32767 then all -32768 → sums saturate neither way; peak 2097088, trough -2097152 after 64 more beats.
- clear mid-RUN with cfg_log2_len switched 2→3 while s_valid=1 → that beat is dropped, m_valid=0 next cycle, new sums restart from the next sample, primed after 8 beats.
- GATE_UNPRIMED=1, L=8 → no m_valid for beats 1–7, first output on beat 8 equals the sum of samples 1–8. Then assert reset_n low mid-stream → outputs zero immediately (asynchronously), and the restart behaves as after power-up.

Source files
------------

// File: rtl/moving_sum_iq.sv
// moving_sum_iq: complex (I/Q) moving-window summer/averager with a runtime
// selectable power-of-two window length, optional divide-by-length output,
// a window-primed flag and a synchronous clear. Valid/ready on both sides.
module moving_sum_iq #(
    parameter int WIDTH         = 16,
    parameter int MAX_LENGTH    = 64,
    parameter int GATE_UNPRIMED = 0
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic [$clog2($clog2(MAX_LENGTH)+1)-1:0]       cfg_log2_len,
    input  logic                                          cfg_average,
    input  logic                                          clear,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic signed [WIDTH-1:0]                       s_data_i,
    input  logic signed [WIDTH-1:0]                       s_data_q,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic signed [WIDTH+$clog2(MAX_LENGTH)-1:0]    m_data_i,
    output logic signed [WIDTH+$clog2(MAX_LENGTH)-1:0]    m_data_q,
    output logic                                          m_primed
);

    localparam int LOG2_MAX = $clog2(MAX_LENGTH);
    localparam int CFG_W    = $clog2(LOG2_MAX + 1);
    localparam int SUM_W    = WIDTH + LOG2_MAX;
    localparam int CNT_W    = LOG2_MAX + 1;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bring an out-of-range window exponent back into 1..LOG2_MAX.
    function automatic logic [CFG_W-1:0] clamp_len(input logic [CFG_W-1:0] raw);
        logic [CFG_W-1:0] result;
        result = raw;
        if (raw == '0) begin
            result = CFG_W'(1);
        end else if (int'(raw) > LOG2_MAX) begin
            result = CFG_W'(LOG2_MAX);
        end
        return result;
    endfunction

    logic                    cfg_pending;
    logic [CFG_W-1:0]        len_log2_q;
    logic                    avg_q;
    logic [CFG_W-1:0]        len_log2;
    logic                    avg_en;
    logic [CNT_W-1:0]        len_val;
    logic [LOG2_MAX-1:0]     len_last;

    state_t                  state;
    state_t                  state_next;
    logic [LOG2_MAX-1:0]     wr_ptr;
    logic [CNT_W-1:0]        fill_cnt;
    logic [CNT_W-1:0]        fill_inc;
    logic                    fill_done;
    logic                    primed_next;
    logic                    emit;
    logic                    accept;

    logic [2*WIDTH-1:0]      mem [MAX_LENGTH];
    logic [2*WIDTH-1:0]      expired;
    logic signed [SUM_W-1:0] sum_i;
    logic signed [SUM_W-1:0] sum_q;
    logic signed [SUM_W-1:0] new_i_ext;
    logic signed [SUM_W-1:0] new_q_ext;
    logic signed [SUM_W-1:0] old_i_ext;
    logic signed [SUM_W-1:0] old_q_ext;
    logic signed [SUM_W-1:0] sum_i_next;
    logic signed [SUM_W-1:0] sum_q_next;
    logic signed [SUM_W-1:0] out_i;
    logic signed [SUM_W-1:0] out_q;

    // Input side stalls on clear and whenever the output register is full and blocked.
    assign s_ready = !clear && (!m_valid || m_ready);
    assign accept  = s_valid && s_ready;

    // Config registers: loaded on the first clock after reset release and on clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_pending <= 1'b1;
            len_log2_q  <= CFG_W'(1);
            avg_q       <= 1'b0;
        end else if (cfg_pending || clear) begin
            cfg_pending <= 1'b0;
            len_log2_q  <= clamp_len(cfg_log2_len);
            avg_q       <= cfg_average;
        end
    end

    // Effective config: the pins are live only in the cycle that latches them.
    always_comb begin
        len_log2 = len_log2_q;
        avg_en   = avg_q;
        if (cfg_pending) begin
            len_log2 = clamp_len(cfg_log2_len);
            avg_en   = cfg_average;
        end
        len_val  = CNT_W'(1) << len_log2;
        len_last = LOG2_MAX'(len_val - CNT_W'(1));
    end

    // Window arithmetic: add the new sample, drop the one leaving the window.
    always_comb begin
        expired     = (state == FILL) ? '0 : mem[wr_ptr];
        new_i_ext   = {{LOG2_MAX{s_data_i[WIDTH-1]}}, s_data_i};
        new_q_ext   = {{LOG2_MAX{s_data_q[WIDTH-1]}}, s_data_q};
        old_i_ext   = {{LOG2_MAX{expired[WIDTH-1]}}, expired[WIDTH-1:0]};
        old_q_ext   = {{LOG2_MAX{expired[2*WIDTH-1]}}, expired[2*WIDTH-1:WIDTH]};
        sum_i_next  = sum_i + new_i_ext - old_i_ext;
        sum_q_next  = sum_q + new_q_ext - old_q_ext;
        out_i       = avg_en ? (sum_i_next >>> len_log2) : sum_i_next;
        out_q       = avg_en ? (sum_q_next >>> len_log2) : sum_q_next;
        fill_inc    = fill_cnt + CNT_W'(1);
        fill_done   = (state == FILL) && (fill_inc == len_val);
        primed_next = (state == RUN) || fill_done;
        emit        = (GATE_UNPRIMED == 0) || primed_next;
    end

    // State register for the FILL/RUN window tracker.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state: clear always restarts filling; the L-th accept enters RUN.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = FILL;
        end else if (accept && fill_done) begin
            state_next = RUN;
        end
    end

    // Sample storage; contents before the window fills are masked by FILL.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {s_data_q, s_data_i};
        end
    end

    // Pointer, fill count, running sums and the output beat register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            fill_cnt <= '0;
            sum_i    <= '0;
            sum_q    <= '0;
            m_valid  <= 1'b0;
            m_primed <= 1'b0;
            m_data_i <= '0;
            m_data_q <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            fill_cnt <= '0;
            sum_i    <= '0;
            sum_q    <= '0;
            m_valid  <= 1'b0;
            m_primed <= 1'b0;
        end else if (accept) begin
            wr_ptr   <= (wr_ptr == len_last) ? '0 : wr_ptr + LOG2_MAX'(1);
            if (state == FILL) begin
                fill_cnt <= fill_inc;
            end
            sum_i    <= sum_i_next;
            sum_q    <= sum_q_next;
            m_data_i <= out_i;
            m_data_q <= out_q;
            m_primed <= primed_next;
            m_valid  <= emit;
        end else if (m_ready) begin
            m_valid  <= 1'b0;
        end
    end

endmodule
